image_line_feeder: RTL and testbench

- Upstream source for the image processing top: reads a raw 8-bit grayscale image from a synchronous pixel memory and streams it as line bursts into the top's input pixel interface.
- Sends PRIME_LINES lines unconditionally, then one further line per rising edge of the top's output interrupt.
- After the last image line, sends PAD_LINES all-zero lines, one per interrupt, so the filter window can flush the bottom rows.
- Replaces bench-driven stimulus with synthesizable sequencing.

---
 rtl/img_pkg.sv | 10 +
 rtl/intr_credit_counter.sv | 34 +++
 rtl/image_line_feeder.sv | 112 +++++++++++
 tb/tb_image_line_feeder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// img_pkg: shared constants and FSM state type for the image line feeder
// Ports: none (package only).
package img_pkg;
    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int PIX_W          = 8;
    localparam int CREDIT_W       = 3;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_FINISH} state_t;
endpackage

// File: rtl/intr_credit_counter.sv
// intr_credit_counter: rising-edge detect on the interrupt plus a saturating credit bank
// Ports: clk/rst clock and sync reset; i_en enables banking (cleared while low);
//        i_intr interrupt level; i_dec consume one credit; o_avail a credit is usable now.
module intr_credit_counter
    import img_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_intr,
    input  logic i_dec,
    output logic o_avail
);
    logic                r_intr_d;
    logic [CREDIT_W-1:0] r_count;
    logic                w_rise;
    logic                w_inc;

    assign w_rise  = i_intr & ~r_intr_d & i_en;
    // At saturation a rise only counts if it is being consumed in the same cycle
    assign w_inc   = w_rise & ((r_count != CREDIT_MAX) | i_dec);
    // A rise arriving this cycle can be spent immediately
    assign o_avail = (r_count != '0) | w_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_intr_d <= 1'b0;
            r_count  <= '0;
        end else begin
            r_intr_d <= i_intr;
            r_count  <= i_en ? r_count + CREDIT_W'(w_inc) - CREDIT_W'(i_dec) : '0;
        end
    end
endmodule

// File: rtl/image_line_feeder.sv
// image_line_feeder: streams an image from pixel memory as interrupt-paced line bursts
// Ports: axi_clk/axi_reset clock and sync reset; start/busy/done frame control;
//        mem_rd_en/mem_addr/mem_rd_data synchronous memory read port (1-cycle latency);
//        intr_in downstream interrupt level; pixel_data/pixel_data_valid output stream.
module image_line_feeder
    import img_pkg::*;
#(
    parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    input  logic              intr_in,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              pixel_data_valid
);
    localparam int TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
    localparam int LINE_W      = $clog2(TOTAL_LINES + 1);
    localparam int COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [LINE_W-1:0] L_H     = LINE_W'(IMG_HEIGHT);
    localparam logic [LINE_W-1:0] L_END   = LINE_W'(TOTAL_LINES);
    localparam logic [LINE_W-1:0] L_PRIME = LINE_W'(PRIME_LINES);
    localparam logic [COL_W-1:0]  C_LAST  = COL_W'(IMG_WIDTH - 1);

    state_t              r_state;
    state_t              w_state_n;
    logic [LINE_W-1:0]   r_line;
    logic [COL_W-1:0]    r_col;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_valid;
    logic                r_pad;
    logic                r_done;
    logic [LINE_W-1:0]   w_line_inc;
    logic                w_send;
    logic                w_pad;
    logic                w_last_col;
    logic                w_dec;
    logic                w_avail;

    intr_credit_counter u_credit (
        .clk     (axi_clk),
        .rst     (axi_reset),
        .i_en    (r_state != S_IDLE),
        .i_intr  (intr_in),
        .i_dec   (w_dec),
        .o_avail (w_avail)
    );

    assign w_send     = r_state == S_SEND;
    assign w_pad      = r_line >= L_H;
    assign w_last_col = r_col == C_LAST;
    assign w_line_inc = r_line + LINE_W'(1);

    always_comb begin
        w_state_n = r_state;
        w_dec     = 1'b0;
        case (r_state)
            S_IDLE:  w_state_n = start ? S_SEND : S_IDLE;
            S_SEND:  if (w_last_col) w_state_n = (w_line_inc == L_END) ? S_FINISH :
                                                 (w_line_inc < L_PRIME) ? S_SEND : S_WAIT;
            S_WAIT: begin
                w_dec     = w_avail;
                w_state_n = w_avail ? S_SEND : S_WAIT;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            r_state <= S_IDLE;
            r_line  <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_pad   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_valid <= w_send;
            r_pad   <= w_pad;
            // FINISH lasts one cycle so done lands after the last pixel has left the pipe
            r_done  <= r_state == S_FINISH;
            if (r_state == S_IDLE && start) begin
                r_line <= '0;
                r_col  <= '0;
                r_addr <= '0;
            end else if (w_send) begin
                r_col <= w_last_col ? '0 : r_col + COL_W'(1);
                if (w_last_col) r_line <= w_line_inc;
                if (!w_pad) r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign busy             = r_state != S_IDLE;
    assign done             = r_done;
    assign mem_rd_en        = w_send & ~w_pad;
    assign mem_addr         = r_addr;
    assign pixel_data_valid = r_valid;
    // Memory data arrives in the same cycle the registered valid does; pad lines force zero
    assign pixel_data       = (r_valid & ~r_pad) ? mem_rd_data : '0;
endmodule

// File: tb/tb_image_line_feeder.sv
// tb_image_line_feeder: directed, self-checking bench for image_line_feeder on a 4x6 image
module tb_image_line_feeder;
    localparam int W     = 4;
    localparam int H     = 6;
    localparam int PRIME = 4;
    localparam int PAD   = 2;
    localparam int TOT   = (H + PAD) * W;

    logic       axi_clk = 1'b0;
    logic       axi_reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [4:0] mem_addr;
    logic [7:0] mem_rd_data = 8'd0;
    logic       intr_in;
    logic [7:0] pixel_data;
    logic       pixel_data_valid;

    logic [7:0]  mem [0:31];
    logic [99:0] ip, sp, rp;

    int total = 0, bad = 0;
    int cyc = 0, t_start = 0;
    int n_valid, n_reads, n_done, done_rel, rises, lines_started, prev_rel;
    int vrel [0:63];
    logic intr_prev = 1'b0;

    image_line_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(PRIME),
                        .PAD_LINES(PAD), .ADDR_W(5)) dut (
        .axi_clk          (axi_clk),
        .axi_reset        (axi_reset),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rd_data      (mem_rd_data),
        .intr_in          (intr_in),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid)
    );

    always #5 axi_clk = ~axi_clk;

    initial for (int i = 0; i < 32; i++) mem[i] = (i < H * W) ? 8'(i) : 8'hEE;

    always @(posedge axi_clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Model: pixel n of a frame is n for image rows and 0 for pad rows, addresses run 0..H*W-1,
    // lines never have bubbles, and each line past the prime set needs an interrupt rise first.
    task automatic compare();
        int rel;
        rel = cyc - t_start;
        if (intr_in && !intr_prev && rel >= 1 && n_done == 0) rises++;
        intr_prev = intr_in;
        if (pixel_data_valid) begin
            chk("pixel_in_frame", int'(n_valid < TOT), 1);
            chk("pixel_value", pixel_data, (n_valid < H * W) ? n_valid : 0);
            if (n_valid % W != 0) chk("no_bubble", rel, prev_rel + 1);
            else if (n_valid / W >= PRIME) begin
                lines_started++;
                chk("credit_gate", int'(lines_started <= rises), 1);
            end
            if (n_valid < 64) vrel[n_valid] = rel;
            prev_rel = rel;
            n_valid++;
        end
        if (mem_rd_en) begin
            chk("mem_addr", mem_addr, n_reads);
            n_reads++;
        end
        if (done) begin
            chk("done_after_all_pixels", n_valid, TOT);
            n_done++;
            done_rel = rel;
        end
    endtask

    task automatic step(input logic s, input logic r, input logic i);
        start = s;
        axi_reset = r;
        intr_in = i;
        @(negedge axi_clk);
        compare();
        @(posedge axi_clk);
        #1;
        cyc++;
    endtask

    task automatic new_frame();
        n_valid = 0; n_reads = 0; n_done = 0; done_rel = -1;
        rises = 0; lines_started = 0; prev_rel = -100;
        t_start = cyc;
    endtask

    task automatic run(input int n);
        int rel;
        for (int k = 0; k < n; k++) begin
            rel = cyc - t_start;
            step(rel == 0 ? 1'b1 : sp[rel], rp[rel], ip[rel]);
        end
    endtask

    task automatic clear_pats();
        ip = '0; sp = '0; rp = '0;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        axi_reset = 1'b1; start = 1'b0; intr_in = 1'b0;
        new_frame();
        repeat (3) @(posedge axi_clk);
        #1;
        axi_reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", pixel_data_valid, 0);
        chk("rst_pixel", pixel_data, 0);

        // Prime lines only, no interrupts: stalls in WAIT after 16 pixels
        clear_pats(); new_frame(); run(40);
        chk("t1_valid", n_valid, 16);
        chk("t1_first", vrel[0], 2);
        chk("t1_last", vrel[15], 17);
        chk("t1_reads", n_reads, 16);
        chk("t1_busy", busy, 1);
        chk("t1_done", n_done, 0);
        chk("t1_rd_idle", mem_rd_en, 0);
        do_reset();

        // One rise in each WAIT
        clear_pats(); ip[17] = 1; ip[22] = 1; ip[27] = 1; ip[32] = 1;
        new_frame(); run(45);
        chk("t2_valid", n_valid, 32);
        chk("t2_reads", n_reads, 24);
        chk("t2_done_cnt", n_done, 1);
        chk("t2_done_rel", done_rel, 38);
        chk("t2_line4", vrel[16], 19);
        chk("t2_last", vrel[31], 37);
        chk("t2_busy", busy, 0);

        // Three banked rises early, fourth later
        clear_pats(); ip[1] = 1; ip[3] = 1; ip[5] = 1; ip[40] = 1;
        new_frame(); run(50);
        chk("t3_line4", vrel[16], 19);
        chk("t3_line5", vrel[20], 24);
        chk("t3_pad0", vrel[24], 29);
        chk("t3_pad1", vrel[28], 42);
        chk("t3_done_rel", done_rel, 46);
        chk("t3_valid", n_valid, 32);
        do_reset();

        // Level held high counts once
        clear_pats(); for (int i = 2; i < 22; i++) ip[i] = 1;
        new_frame(); run(35);
        chk("t4_valid", n_valid, 20);
        chk("t4_line4_end", vrel[19], 22);
        do_reset();

        // Eight rises saturate the bank at seven
        clear_pats(); for (int i = 1; i < 16; i += 2) ip[i] = 1;
        new_frame(); run(16);
        chk("t4_sat", dut.u_credit.r_count, 7);
        run(30);
        chk("t4_sat_valid", n_valid, 32);
        chk("t4_sat_done", done_rel, 38);
        do_reset();

        // Reset in the middle of line 2, then a clean replay
        clear_pats(); ip[17] = 1; ip[22] = 1; ip[27] = 1; ip[32] = 1; rp[10] = 1;
        new_frame(); run(11);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_rd_en", mem_rd_en, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_valid_out", pixel_data_valid, 0);
        chk("t5_pixel", pixel_data, 0);
        chk("t5_valid_before", n_valid, 9);
        chk("t5_reads_before", n_reads, 10);
        rp = '0;
        new_frame(); run(45);
        chk("t5_replay_valid", n_valid, 32);
        chk("t5_replay_reads", n_reads, 24);
        chk("t5_replay_done", done_rel, 38);

        // Start while busy and in FINISH is ignored
        clear_pats(); ip[17] = 1; ip[22] = 1; ip[27] = 1; ip[32] = 1;
        sp[6] = 1; sp[20] = 1; sp[37] = 1;
        new_frame(); run(45);
        chk("t6_valid", n_valid, 32);
        chk("t6_reads", n_reads, 24);
        chk("t6_done_cnt", n_done, 1);
        chk("t6_done_rel", done_rel, 38);
        chk("t6_busy", busy, 0);

        // Reset wins over a coincident start
        new_frame();
        step(1'b1, 1'b1, 1'b0);
        chk("t7_busy_now", busy, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("t7_busy_later", busy, 0);
        chk("t7_reads", n_reads, 0);
        chk("t7_valid", n_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
